// File: rtl/popcount_hist_pkg.sv
`default_nettype none
// ============================================================================
// popcount_hist_pkg : shared FSM type and sizing helper for the histogram
// Revision : 1.0
// ============================================================================
package popcount_hist_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_t;

  function automatic int bin_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_hist_bin_bank.sv
`default_nettype none
// ============================================================================
// popcount_hist_bin_bank : WIDTH+1 saturating bin counters, one increment port
//                          and one read-and-clear port
// Revision : 1.0
// ============================================================================
module popcount_hist_bin_bank
  import popcount_hist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 9,
  parameter int BIN_W = bin_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             inc_en_i,
  input  logic [BIN_W-1:0] inc_idx_i,
  input  logic             clr_en_i,
  input  logic [BIN_W-1:0] clr_idx_i,
  input  logic [BIN_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic             rd_sat_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [WIDTH:0][CNT_W-1:0] r_cnt;
  logic [WIDTH:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH:0]            r_sat;
  logic [WIDTH:0]            w_sat_nxt;

  // Out-of-range indices match no bin, so they are silently ignored.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    for (int i = 0; i <= WIDTH; i++) begin
      if (clr_en_i && (clr_idx_i == BIN_W'(i))) begin
        w_cnt_nxt[i] = '0;
        w_sat_nxt[i] = 1'b0;
      end else if (inc_en_i && (inc_idx_i == BIN_W'(i))) begin
        if (r_cnt[i] == c_cnt_max) begin
          w_sat_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The read port returns the post-update value so the caller can register it
  // and still see a same-cycle increment.
  always_comb begin
    rd_cnt_o = '0;
    rd_sat_o = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (rd_idx_i == BIN_W'(i)) begin
        rd_cnt_o = w_cnt_nxt[i];
        rd_sat_o = w_sat_nxt[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt <= '0;
      r_sat <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/popcount_histogram.sv
`default_nettype none
// ============================================================================
// popcount_histogram : per-value histogram of popcount results over a frame,
//                      dumped bin by bin over valid/ready at frame end
// Revision : 1.0
// ============================================================================
module popcount_histogram
  import popcount_hist_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [bin_w(WIDTH)-1:0]   data_i,
  input  logic                      data_val_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      drop_o,
  output logic [bin_w(WIDTH)-1:0]   hist_bin_o,
  output logic [CNT_W-1:0]          hist_cnt_o,
  output logic                      hist_sat_o,
  output logic                      hist_val_o,
  output logic                      hist_last_o,
  input  logic                      hist_ready_i
);

  localparam int                    c_bin_w     = bin_w(WIDTH);
  localparam int                    c_smp_w     = $clog2(FRAME_LEN + 1);
  localparam logic [c_bin_w-1:0]    c_last_bin  = c_bin_w'(WIDTH);
  localparam logic [c_smp_w-1:0]    c_frame_end = c_smp_w'(FRAME_LEN - 1);

  state_t               r_state;
  logic [c_smp_w-1:0]   r_smp_cnt;
  logic                 r_drop;
  logic                 r_hist_val;
  logic                 r_hist_last;
  logic [c_bin_w-1:0]   r_hist_bin;
  logic [CNT_W-1:0]     r_hist_cnt;
  logic                 r_hist_sat;

  logic                 w_accept;
  logic                 w_frame_end;
  logic                 w_word_acc;
  logic [c_bin_w-1:0]   w_rd_idx;
  logic [CNT_W-1:0]     w_rd_cnt;
  logic                 w_rd_sat;

  assign w_accept    = (r_state == ACCUM) && data_val_i;
  assign w_frame_end = (r_state == ACCUM) &&
                       ((w_accept && (r_smp_cnt == c_frame_end)) ||
                        (flush_i && ((r_smp_cnt != '0) || w_accept)));
  assign w_word_acc  = (r_state == DUMP) && r_hist_val && hist_ready_i;

  // Index of the word that will be presented next cycle.
  always_comb begin
    w_rd_idx = r_hist_bin;
    if (r_state == ACCUM) begin
      w_rd_idx = '0;
    end else if (w_word_acc) begin
      w_rd_idx = r_hist_bin + 1'b1;
    end
  end

  popcount_hist_bin_bank #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .BIN_W (c_bin_w)
  ) u_bank (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .inc_en_i  (w_accept),
    .inc_idx_i (data_i),
    .clr_en_i  (w_word_acc),
    .clr_idx_i (r_hist_bin),
    .rd_idx_i  (w_rd_idx),
    .rd_cnt_o  (w_rd_cnt),
    .rd_sat_o  (w_rd_sat)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state     <= ACCUM;
      r_smp_cnt   <= '0;
      r_drop      <= 1'b0;
      r_hist_val  <= 1'b0;
      r_hist_last <= 1'b0;
      r_hist_bin  <= '0;
      r_hist_cnt  <= '0;
      r_hist_sat  <= 1'b0;
    end else begin
      r_drop <= data_val_i && (r_state == DUMP);
      case (r_state)
        ACCUM: begin
          if (w_frame_end) begin
            r_state     <= DUMP;
            r_smp_cnt   <= '0;
            r_hist_val  <= 1'b1;
            r_hist_bin  <= '0;
            r_hist_last <= (WIDTH == 0);
            r_hist_cnt  <= w_rd_cnt;
            r_hist_sat  <= w_rd_sat;
          end else if (w_accept) begin
            r_smp_cnt <= r_smp_cnt + 1'b1;
          end
        end
        DUMP: begin
          if (w_word_acc) begin
            if (r_hist_last) begin
              r_state     <= ACCUM;
              r_hist_val  <= 1'b0;
              r_hist_last <= 1'b0;
              r_hist_bin  <= '0;
              r_hist_cnt  <= '0;
              r_hist_sat  <= 1'b0;
            end else begin
              r_hist_bin  <= w_rd_idx;
              r_hist_last <= (w_rd_idx == c_last_bin);
              r_hist_cnt  <= w_rd_cnt;
              r_hist_sat  <= w_rd_sat;
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign busy_o      = (r_state == DUMP);
  assign drop_o      = r_drop;
  assign hist_bin_o  = r_hist_bin;
  assign hist_cnt_o  = r_hist_cnt;
  assign hist_sat_o  = r_hist_sat;
  assign hist_val_o  = r_hist_val;
  assign hist_last_o = r_hist_last;

endmodule
`default_nettype wire

// File: tb/tb_popcount_histogram.sv
`default_nettype none
// ============================================================================
// tb_popcount_histogram : directed self-checking bench for popcount_histogram
// Revision : 1.0
// ============================================================================
module tb_popcount_histogram;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst_a, srst_b, dval, flush, rdy, sel_b;
  logic [3:0] data;

  logic       busy_a, drop_a, val_a, last_a, sat_a;
  logic [3:0] bin_a;
  logic [2:0] cnt_a;
  logic       busy_b, drop_b, val_b, last_b, sat_b;
  logic [3:0] bin_b;
  logic [1:0] cnt_b;

  popcount_histogram #(.WIDTH(8), .FRAME_LEN(4)) dut_a (
    .clk_i(clk), .srst_i(srst_a), .data_i(data), .data_val_i(dval), .flush_i(flush),
    .busy_o(busy_a), .drop_o(drop_a), .hist_bin_o(bin_a), .hist_cnt_o(cnt_a),
    .hist_sat_o(sat_a), .hist_val_o(val_a), .hist_last_o(last_a), .hist_ready_i(rdy)
  );

  popcount_histogram #(.WIDTH(8), .FRAME_LEN(6), .CNT_W(2)) dut_b (
    .clk_i(clk), .srst_i(srst_b), .data_i(data), .data_val_i(dval), .flush_i(flush),
    .busy_o(busy_b), .drop_o(drop_b), .hist_bin_o(bin_b), .hist_cnt_o(cnt_b),
    .hist_sat_o(sat_b), .hist_val_o(val_b), .hist_last_o(last_b), .hist_ready_i(rdy)
  );

  logic       m_busy, m_drop, m_val, m_last, m_sat;
  logic [3:0] m_bin;
  logic [2:0] m_cnt;

  always_comb begin
    m_busy = sel_b ? busy_b : busy_a;
    m_drop = sel_b ? drop_b : drop_a;
    m_val  = sel_b ? val_b  : val_a;
    m_last = sel_b ? last_b : last_a;
    m_sat  = sel_b ? sat_b  : sat_a;
    m_bin  = sel_b ? bin_b  : bin_a;
    m_cnt  = sel_b ? {1'b0, cnt_b} : cnt_a;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_drop   = 0;
  int exp_cnt[9];
  int exp_sat[9];

  always @(posedge clk) if (drop_a) n_drop <= n_drop + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int v);
    data = 4'(v);
    dval = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 9; i++) begin
      exp_cnt[i] = 0;
      exp_sat[i] = 0;
    end
  endtask

  // Called at the negedge where the first dump word should be visible.
  task automatic dump(input bit toggle);
    int k = 0;
    int guard = 0;
    while (k < 9 && guard < 64) begin
      chk($sformatf("val w%0d", k),  m_val,  1);
      chk($sformatf("busy w%0d", k), m_busy, 1);
      chk($sformatf("bin w%0d", k),  m_bin,  k);
      chk($sformatf("cnt w%0d", k),  m_cnt,  exp_cnt[k]);
      chk($sformatf("sat w%0d", k),  m_sat,  exp_sat[k]);
      chk($sformatf("last w%0d", k), m_last, (k == 8) ? 1 : 0);
      rdy = toggle ? ~rdy : 1'b1;
      if (rdy) k++;
      @(negedge clk);
      guard++;
    end
    if (k < 9) chk("dump timeout", k, 9);
    rdy = 1'b1;
    chk("val after dump", m_val, 0);
    chk("busy after dump", m_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    srst_a = 1'b1; srst_b = 1'b1; dval = 1'b0; flush = 1'b0;
    rdy = 1'b1; data = '0; sel_b = 1'b0;
    clear_exp();
    repeat (3) @(negedge clk);
    srst_a = 1'b0;

    chk("rst val",  m_val,  0);
    chk("rst busy", m_busy, 0);
    chk("rst drop", m_drop, 0);
    chk("rst last", m_last, 0);
    chk("rst bin",  m_bin,  0);
    chk("rst cnt",  m_cnt,  0);
    chk("rst sat",  m_sat,  0);

    // Full frame
    send(3); send(3); send(0); send(8);
    dval = 1'b0;
    clear_exp(); exp_cnt[0] = 1; exp_cnt[3] = 2; exp_cnt[8] = 1;
    dump(1'b0);

    // Early flush, empty flush, flush together with the only sample
    send(5); send(5);
    dval = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_exp(); exp_cnt[5] = 2;
    dump(1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("empty flush busy", m_busy, 0);
    chk("empty flush val", m_val, 0);
    @(negedge clk);
    chk("empty flush val2", m_val, 0);
    data = 4'd6; dval = 1'b1; flush = 1'b1;
    @(negedge clk);
    dval = 1'b0; flush = 1'b0;
    clear_exp(); exp_cnt[6] = 1;
    dump(1'b0);

    // Back-pressure, then a frame with an out-of-range value
    send(1); send(1); send(1); send(1);
    dval = 1'b0;
    clear_exp(); exp_cnt[1] = 4;
    dump(1'b1);
    send(4); send(4); send(15); send(7);
    dval = 1'b0;
    clear_exp(); exp_cnt[4] = 2; exp_cnt[7] = 1;
    dump(1'b0);

    // Samples held across a dump are dropped; the one after last accept counts
    base = n_drop;
    send(2); send(2); send(2); send(2);
    data = 4'd7;
    clear_exp(); exp_cnt[2] = 4;
    dump(1'b0);
    send(6); send(6); send(6); send(6);
    dval = 1'b0;
    clear_exp(); exp_cnt[6] = 4;
    dump(1'b0);
    chk("drop count", n_drop - base, 9);
    chk("drop idle", m_drop, 0);

    // Reset in the middle of a dump
    send(6); send(6); send(6); send(6);
    dval = 1'b0;
    g = 0;
    while (m_bin != 4'd4 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("abort at bin", m_bin, 4);
    srst_a = 1'b1;
    @(negedge clk);
    srst_a = 1'b0;
    chk("abort val", m_val, 0);
    chk("abort busy", m_busy, 0);
    chk("abort cnt", m_cnt, 0);
    send(1); send(1); send(1); send(1);
    dval = 1'b0;
    clear_exp(); exp_cnt[1] = 4;
    dump(1'b0);

    // Saturation on the narrow-counter instance
    srst_a = 1'b1;
    sel_b  = 1'b1;
    srst_b = 1'b0;
    @(negedge clk);
    chk("b rst val", m_val, 0);
    chk("b rst busy", m_busy, 0);
    for (int i = 0; i < 6; i++) send(2);
    dval = 1'b0;
    clear_exp(); exp_cnt[2] = 3; exp_sat[2] = 1;
    dump(1'b0);
    send(1); send(1); send(2); send(4); send(4); send(0);
    dval = 1'b0;
    clear_exp(); exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 1; exp_cnt[4] = 2;
    dump(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
